// File: rtl/iterative_divider_if.sv
// Request/result bundle between the EX stage and the iterative divider.
// The master drives operands and start; the slave returns status and results.
interface iterative_divider_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/iterative_divider.sv
// Restoring divider for RV32M DIV/DIVU/REM/REMU: one shift-and-subtract step per clock.
// Fixed latency of WIDTH+2 busy cycles, with RISC-V divide-by-zero and overflow results.
module iterative_divider #(
   parameter int unsigned WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   iterative_divider_if.slave bus
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    LastCount = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic             accept;
   logic             busy;
   logic             done;

   logic             op_signed_q;
   logic             sign_q_q;
   logic             sign_r_q;
   logic             dbz_q;
   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH:0]   r_q;
   logic [CW-1:0]    count_q;

   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             div_by_zero_q;

   // Operand magnitudes, taken only for signed operations.
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   r_sub;
   logic             r_ge;
   logic [WIDTH:0]   r_step;
   logic [WIDTH-1:0] q_step;

   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic [WIDTH-1:0] quotient_d;
   logic [WIDTH-1:0] remainder_d;

   // ---------------------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = StCalc;
            end
         end
         StCalc: begin
            busy = 1'b1;
            if (count_q == LastCount) begin
               state_d = StFix;
            end
         end
         StFix: begin
            busy    = 1'b1;
            state_d = StDone;
         end
         StDone: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // Operand capture
   // ---------------------------------------------------------------------------------------
   always_comb begin
      a_neg = bus.signed_op & bus.dividend[WIDTH-1];
      b_neg = bus.signed_op & bus.divisor[WIDTH-1];
      a_mag = a_neg ? (~bus.dividend + One) : bus.dividend;
      b_mag = b_neg ? (~bus.divisor + One) : bus.divisor;
   end

   // ---------------------------------------------------------------------------------------
   // One restoring step: shift in the next dividend bit, subtract if it fits
   // ---------------------------------------------------------------------------------------
   always_comb begin
      r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      r_sub   = r_shift - {1'b0, divisor_q};
      r_ge    = (r_shift >= {1'b0, divisor_q});
      r_step  = r_ge ? r_sub : r_shift;
      q_step  = {q_q[WIDTH-2:0], r_ge};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_signed_q <= 1'b0;
         sign_q_q    <= 1'b0;
         sign_r_q    <= 1'b0;
         dbz_q       <= 1'b0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         q_q         <= '0;
         r_q         <= '0;
         count_q     <= '0;
      end else if (accept) begin
         op_signed_q <= bus.signed_op;
         sign_q_q    <= a_neg ^ b_neg;
         sign_r_q    <= a_neg;
         dbz_q       <= (bus.divisor == '0);
         dividend_q  <= bus.dividend;
         divisor_q   <= b_mag;
         q_q         <= a_mag;
         r_q         <= '0;
         count_q     <= '0;
      end else if (state_q == StCalc) begin
         q_q     <= q_step;
         r_q     <= r_step;
         count_q <= count_q + CW'(1);
      end
   end

   // ---------------------------------------------------------------------------------------
   // Sign fix-up and special-case override
   // ---------------------------------------------------------------------------------------
   always_comb begin
      q_fix = (op_signed_q & sign_q_q) ? (~q_q + One) : q_q;
      r_fix = (op_signed_q & sign_r_q) ? (~r_q[WIDTH-1:0] + One) : r_q[WIDTH-1:0];
      // Signed overflow needs no override: |MIN|/1 negated twice lands back on MIN.
      if (dbz_q) begin
         quotient_d  = '1;
         remainder_d = dividend_q;
      end else begin
         quotient_d  = q_fix;
         remainder_d = r_fix;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else if (state_q == StFix) begin
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= dbz_q;
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = div_by_zero_q;

   // With a non-zero divisor the partial remainder stays below it, so the extra bit is spare.
   partial_rem_fits: assert property (@(posedge clk) disable iff (rst || dbz_q)
      (state_q == StCalc) |-> (r_q[WIDTH] == 1'b0));

endmodule
